// File: rtl/hfrv_trace_buffer_if.sv
// Commit-side and drain-side signal bundle for the retire-trace recorder.
// Drain handshake: a record moves on a clock edge where rd_valid && rd_ready; while
// rd_valid is high and rd_ready low, rd_data is held unchanged and rd_valid stays high.
interface hfrv_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic                 commit_valid;
  logic [XLEN-1:0]      commit_pc;
  logic [31:0]          commit_instr;
  logic [4:0]           commit_rd;
  logic [XLEN-1:0]      commit_wdata;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [2*XLEN+36:0]   rd_data;

  modport master (
    output commit_valid, commit_pc, commit_instr, commit_rd, commit_wdata, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_rd, commit_wdata, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/hfrv_trace_buffer.sv
// Retire-trace recorder: captures committed-instruction records into a circular
// buffer (fill-stop or pc-triggered pre/post window) and drains them oldest-first.
module hfrv_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int POST_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int REC_W = 2*XLEN+37
) (
  input  logic                clk,
  input  logic                reset,
  hfrv_trace_buffer_if.slave  bus,
  input  logic                arm,
  input  logic                stop,
  input  logic                cfg_mode,
  input  logic [XLEN-1:0]     cfg_trig_pc,
  input  logic [POST_W-1:0]   cfg_post_count,
  output logic [1:0]          state,
  output logic                triggered,
  output logic [PTR_W:0]      count,
  output logic [15:0]         dropped
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH-1);

  state_t              st;
  logic [REC_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                mode_q;
  logic [XLEN-1:0]     trig_pc_q;
  logic [POST_W-1:0]   post_cfg_q;
  logic [POST_W-1:0]   post_left;

  logic capturing;
  logic wr_en;
  logic full;
  logic pc_hit;
  logic rd_fire;

  assign capturing = (st == S_CAPTURE) || (st == S_POST);
  // arm and stop both win over a coincident commit, so the write is suppressed too.
  assign wr_en     = capturing && bus.commit_valid && !arm && !stop && !reset;
  assign full      = (count == CNT_FULL);
  assign pc_hit    = (bus.commit_pc == trig_pc_q);

  assign bus.rd_valid = (st == S_DONE) && (count != '0);
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
  assign rd_fire      = bus.rd_valid && bus.rd_ready;

  assign state = st;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.commit_pc, bus.commit_instr, bus.commit_rd, bus.commit_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dropped    <= '0;
      triggered  <= 1'b0;
      mode_q     <= 1'b0;
      trig_pc_q  <= '0;
      post_cfg_q <= '0;
      post_left  <= '0;
    end else if (arm) begin
      st         <= S_CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dropped    <= '0;
      triggered  <= 1'b0;
      mode_q     <= cfg_mode;
      trig_pc_q  <= cfg_trig_pc;
      post_cfg_q <= cfg_post_count;
      post_left  <= '0;
    end else begin
      case (st)
        S_CAPTURE, S_POST: begin
          if (stop) begin
            st <= S_DONE;
          end else if (bus.commit_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            // Full buffer: the new record replaces the oldest one.
            if (full) begin
              rd_ptr <= rd_ptr + 1'b1;
              if (dropped != 16'hFFFF) begin
                dropped <= dropped + 16'd1;
              end
            end else begin
              count <= count + 1'b1;
            end

            if (!mode_q) begin
              if (count == CNT_LAST) begin
                st <= S_DONE;
              end
            end else if (st == S_CAPTURE) begin
              if (pc_hit) begin
                triggered <= 1'b1;
                post_left <= post_cfg_q;
                st        <= (post_cfg_q == '0) ? S_DONE : S_POST;
              end
            end else begin
              post_left <= post_left - 1'b1;
              if (post_left == POST_W'(1)) begin
                st <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Bench for hfrv_trace_buffer: directed scenarios plus randomized runs, each checked
// against a queue-based model of the recorder.
module tb_hfrv_trace_buffer;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 8;
  localparam int POST_W = 8;
  localparam int REC_W  = 2*XLEN+37;
  localparam int ST_W   = 2+1+4+16;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm;
  logic              stop;
  logic              cfg_mode;
  logic [XLEN-1:0]   cfg_trig_pc;
  logic [POST_W-1:0] cfg_post_count;
  logic [1:0]        state;
  logic              triggered;
  logic [3:0]        count;
  logic [15:0]       dropped;
  logic [ST_W-1:0]   act_status;

  hfrv_trace_buffer_if #(.XLEN(XLEN)) bus ();

  hfrv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_W(POST_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .arm            (arm),
    .stop           (stop),
    .cfg_mode       (cfg_mode),
    .cfg_trig_pc    (cfg_trig_pc),
    .cfg_post_count (cfg_post_count),
    .state          (state),
    .triggered      (triggered),
    .count          (count),
    .dropped        (dropped)
  );

  always #5 clk = ~clk;

  assign act_status = {state, triggered, count, dropped};

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];
  int          m_state, m_trig, m_dropped, m_mode, m_post, m_post_left;
  logic [31:0] m_trig_pc;

  function automatic logic [ST_W-1:0] exp_status();
    int c;
    logic [1:0]  s;
    logic [3:0]  cc;
    logic [15:0] d;
    logic        t;
    c  = exp_q.size();
    s  = m_state[1:0];
    t  = m_trig[0];
    cc = c[3:0];
    d  = m_dropped[15:0];
    return {s, t, cc, d};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_state = 0; m_trig = 0; m_dropped = 0; m_mode = 0;
    m_post = 0; m_post_left = 0; m_trig_pc = '0;
  endfunction

  function automatic void model_arm(int mode, logic [31:0] tpc, int post);
    exp_q.delete();
    m_state = 1; m_trig = 0; m_dropped = 0;
    m_mode = mode; m_trig_pc = tpc; m_post = post; m_post_left = 0;
  endfunction

  function automatic void model_stop();
    if (m_state == 1 || m_state == 2) m_state = 3;
  endfunction

  function automatic void model_commit(logic [REC_W-1:0] rec);
    logic [31:0] pc;
    pc = rec[REC_W-1 -: 32];
    if (m_state != 1 && m_state != 2) return;
    exp_q.push_back(rec);
    if (exp_q.size() > DEPTH) begin
      void'(exp_q.pop_front());
      if (m_dropped < 65535) m_dropped++;
    end
    if (m_mode == 0) begin
      if (exp_q.size() == DEPTH) m_state = 3;
    end else if (m_state == 1) begin
      if (pc == m_trig_pc) begin
        m_trig = 1;
        if (m_post == 0) m_state = 3;
        else begin m_post_left = m_post; m_state = 2; end
      end
    end else begin
      m_post_left--;
      if (m_post_left == 0) m_state = 3;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_rec(input logic [31:0] pc, output logic [REC_W-1:0] rec);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_instr = $urandom;
    bus.commit_rd    = 5'($urandom_range(0, 31));
    bus.commit_wdata = $urandom;
    rec = {bus.commit_pc, bus.commit_instr, bus.commit_rd, bus.commit_wdata};
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
  endtask

  task automatic do_arm(input int mode, input logic [31:0] tpc, input int post, input bit with_commit);
    logic [REC_W-1:0] rec;
    arm = 1'b1; cfg_mode = mode[0]; cfg_trig_pc = tpc; cfg_post_count = post[POST_W-1:0];
    if (with_commit) drive_rec(tpc, rec);
    tick();
    arm = 1'b0; bus.commit_valid = 1'b0;
    model_arm(mode, tpc, post);
  endtask

  task automatic do_commit(input logic [31:0] pc);
    logic [REC_W-1:0] rec;
    drive_rec(pc, rec);
    tick();
    bus.commit_valid = 1'b0;
    model_commit(rec);
  endtask

  task automatic do_stop(input bit with_commit);
    logic [REC_W-1:0] rec;
    stop = 1'b1;
    if (with_commit) drive_rec(32'h0000_0ABC, rec);
    tick();
    stop = 1'b0; bus.commit_valid = 1'b0;
    model_stop();
  endtask

  // Collects accepted records into obs_q; stops when rd_valid drops or the budget ends.
  task automatic drain(input bit rand_ready, input int budget);
    logic             v;
    logic [REC_W-1:0] d;
    obs_q.delete();
    for (int n = 0; n < budget; n++) begin
      bus.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      v = bus.rd_valid; d = bus.rd_data;
      if (!v) break;
      tick();
      if (v && bus.rd_ready) obs_q.push_back(d);
    end
    bus.rd_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    model_reset();
    checks++;
    if (act_status !== '0) begin
      errors++; $display("FAIL reset_status: got %h want 0", act_status);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      errors++; $display("FAIL reset_rd: got valid=%b data=%h want 0/0", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_fill_stop();
    logic [31:0] pc;
    do_arm(0, 32'h0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_commit(32'h100 + 32'(4*i));
      checks++;
      if (act_status !== exp_status()) begin
        errors++; $display("FAIL fill_status[%0d]: got %h want %h", i, act_status, exp_status());
      end
      if (i == 7) begin
        checks++;
        if (state !== 2'd3 || count !== 4'd8 || dropped !== 16'd0) begin
          errors++; $display("FAIL fill_done: got st=%0d cnt=%0d drop=%0d want 3/8/0", state, count, dropped);
        end
      end
    end
    drain(1'b0, 40);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL fill_drain_len: got %0d want 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      pc = obs_q[k][REC_W-1 -: 32];
      checks++;
      if (pc !== 32'h100 + 32'(4*k) || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL fill_drain[%0d]: got %h want pc %h rec %h", k, obs_q[k], 32'h100 + 32'(4*k), exp_q[k]);
      end
    end
    exp_q.delete();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL fill_empty: got rd_valid=%b want 0", bus.rd_valid);
    end
  endtask

  task automatic test_trigger();
    logic [31:0] pc;
    do_arm(1, 32'h200, 3, 1'b0);
    for (int i = 0; i < 20; i++) do_commit(32'h1C0 + 32'(4*i));
    checks++;
    if (state !== 2'd3 || triggered !== 1'b1 || count !== 4'd8 || dropped !== 16'd12) begin
      errors++; $display("FAIL trig_final: got st=%0d trg=%b cnt=%0d drop=%0d want 3/1/8/12", state, triggered, count, dropped);
    end
    checks++;
    if (act_status !== exp_status()) begin
      errors++; $display("FAIL trig_status: got %h want %h", act_status, exp_status());
    end
    drain(1'b0, 40);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL trig_drain_len: got %0d want 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      pc = obs_q[k][REC_W-1 -: 32];
      checks++;
      if (pc !== 32'h1F0 + 32'(4*k) || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL trig_drain[%0d]: got %h want pc %h", k, obs_q[k], 32'h1F0 + 32'(4*k));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_post_zero();
    do_arm(1, 32'h40, 0, 1'b0);
    do_commit(32'h40);
    checks++;
    if (state !== 2'd3 || count !== 4'd1 || triggered !== 1'b1) begin
      errors++; $display("FAIL post0_done: got st=%0d cnt=%0d trg=%b want 3/1/1", state, count, triggered);
    end
    do_stop(1'b0);
    do_commit(32'h44);
    checks++;
    if (act_status !== exp_status() || state !== 2'd3 || count !== 4'd1) begin
      errors++; $display("FAIL post0_stop_ignored: got %h want %h", act_status, exp_status());
    end
    drain(1'b0, 10);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL post0_drain: got n=%0d want 1 rec %h", obs_q.size(), exp_q[0]);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [3:0]       pat;
    logic             v, held_ok;
    logic [REC_W-1:0] d, held;
    pat = 4'b1001;
    do_arm(0, 32'h0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_commit($urandom);
    obs_q.delete();
    held_ok = 1'b0; held = '0;
    for (int n = 0; n < 60; n++) begin
      bus.rd_ready = pat[n % 4];
      v = bus.rd_valid; d = bus.rd_data;
      if (!v) break;
      if (held_ok) begin
        checks++;
        if (d !== held) begin
          errors++; $display("FAIL bp_hold[%0d]: got %h want %h", n, d, held);
        end
      end
      tick();
      if (bus.rd_ready) begin obs_q.push_back(d); held_ok = 1'b0; end
      else begin held = d; held_ok = 1'b1; end
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_rec[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_coincident();
    do_arm(1, 32'hFFFF_FFF1, 2, 1'b1);
    checks++;
    if (act_status !== exp_status() || count !== 4'd0) begin
      errors++; $display("FAIL arm_commit: got %h want %h", act_status, exp_status());
    end
    do_commit(32'h10);
    do_commit(32'h14);
    do_stop(1'b1);
    checks++;
    if (act_status !== exp_status() || count !== 4'd2 || state !== 2'd3) begin
      errors++; $display("FAIL stop_commit: got %h want %h", act_status, exp_status());
    end
    do_commit(32'h18);
    drain(1'b0, 10);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL stop_drain: got n=%0d first %h want 2 first %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, exp_q[0]);
    end
    exp_q.delete();
    // reset while half-drained
    do_arm(0, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_commit(32'h300 + 32'(4*i));
    do_stop(1'b0);
    bus.rd_ready = 1'b1; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; bus.rd_ready = 1'b0;
    model_reset();
    checks++;
    if (act_status !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      errors++; $display("FAIL reset_mid_drain: got st=%h v=%b d=%h want all 0", act_status, bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_saturation();
    do_arm(1, 32'h0000_0003, 4, 1'b0);
    for (int i = 0; i < 65600; i++) do_commit(32'(4*i));
    do_stop(1'b0);
    checks++;
    if (dropped !== 16'hFFFF || count !== 4'd8 || state !== 2'd3 || triggered !== 1'b0) begin
      errors++; $display("FAIL saturate: got drop=%h cnt=%0d st=%0d want FFFF/8/3", dropped, count, state);
    end
    checks++;
    if (act_status !== exp_status()) begin
      errors++; $display("FAIL saturate_model: got %h want %h", act_status, exp_status());
    end
    drain(1'b0, 20);
    checks++;
    if (obs_q.size() != 8 || obs_q[0] !== exp_q[0] || obs_q[7] !== exp_q[7]) begin
      errors++; $display("FAIL saturate_drain: got n=%0d want 8", obs_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int          mode, post, n, tidx;
    logic [31:0] pcs[$];
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 1);
      post = $urandom_range(0, 5);
      n    = $urandom_range(4, 20);
      pcs.delete();
      for (int i = 0; i < n; i++) pcs.push_back({$urandom_range(0, 255), 2'b00});
      tidx = $urandom_range(0, n-1);
      do_arm(mode, pcs[tidx], post, 1'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        do_commit(pcs[i]);
      end
      if (m_state != 3) do_stop(1'($urandom_range(0, 1)));
      checks++;
      if (act_status !== exp_status()) begin
        errors++; $display("FAIL rand_status[%0d]: got %h want %h", it, act_status, exp_status());
      end
      drain(1'b1, 100);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_len[%0d]: got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_rec[%0d.%0d]: got %h want %h", it, k, obs_q[k], exp_q[k]);
        end
      end
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; cfg_mode = 1'b0;
    cfg_trig_pc = '0; cfg_post_count = '0;
    bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_instr = '0;
    bus.commit_rd = '0; bus.commit_wdata = '0; bus.rd_ready = 1'b0;
    model_reset();
    test_reset();
    test_fill_stop();
    test_trigger();
    test_post_zero();
    test_backpressure();
    test_coincident();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: got no completion want finish before 5ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hfrv_trace_buffer.md
Name: hfrv_trace_buffer

Overview:
Parametrised on-chip retire-trace recorder for the HF-RISC core. It captures committed-instruction records (pc, instr, rd, wdata) into a circular buffer. Two modes: fill-until-full, or PC-triggered pre/post capture. After capture stops, a valid/ready port drains the records oldest-first. It sits beside the core's commit stage and gives silicon and FPGA builds the same instruction-history view the simulation history dump provides.

Parameters:
XLEN, 32, width of pc and wdata fields
DEPTH, 64, number of entries; power of two, >= 2; PTR_W = $clog2(DEPTH) is derived
POST_W, 8, width of the post-trigger count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
commit_valid  in  1  one retired instruction this cycle
commit_pc  in  XLEN  pc of the retired instruction
commit_instr  in  32  instruction word
commit_rd  in  5  destination register (x0 is still recorded)
commit_wdata  in  XLEN  value written to rd
arm  in  1  pulse; clears the buffer and starts capture
stop  in  1  pulse; forces DONE
cfg_mode  in  1  0 = fill-stop, 1 = triggered circular; sampled on arm
cfg_trig_pc  in  XLEN  trigger pc; sampled on arm
cfg_post_count  in  POST_W  entries recorded after the trigger entry; sampled on arm
rd_valid  out  1  a record is available
rd_ready  in  1  consumer accepts the record
rd_data  out  2*XLEN+37  record packed as {pc, instr, rd, wdata}
state  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3
triggered  out  1  trigger seen since the last arm
count  out  PTR_W+1  entries currently held
dropped  out  16  entries overwritten or discarded; saturates at 16'hFFFF

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-high reset, all state updated on posedge clk.
  - Reset in any state, including mid-capture and mid-drain: state=IDLE, wr_ptr=rd_ptr=0, count=0, dropped=0, triggered=0, rd_valid=0, rd_data=0.
- Priority when signals coincide: reset > arm > stop > commit/read.
- arm (any state): clears pointers, count, dropped and triggered; latches the cfg_* inputs; state becomes CAPTURE. A commit_valid in the arm cycle is NOT recorded.
- stop in CAPTURE or POST: state becomes DONE; a commit in the same cycle is NOT recorded. stop is ignored in IDLE and DONE.
- Recording, in CAPTURE or POST when commit_valid=1:
  - Write the record at wr_ptr; wr_ptr advances and wraps at DEPTH.
  - Record is visible to the drain port one cycle later.
- Mode 0 (fill-stop):
  - The write that makes count==DEPTH also sets state=DONE.
  - Trigger logic is disabled; triggered stays 0.
- Mode 1, CAPTURE:
  - When full, the new write overwrites the oldest entry: rd_ptr advances, count stays DEPTH, dropped increments.
  - When commit_pc==cfg_trig_pc: record the entry, set triggered=1, load post_left=cfg_post_count.
  - If cfg_post_count==0, go to DONE in the same clock; otherwise go to POST.
- Mode 1, POST:
  - Each commit is recorded with the same overwrite rule, and post_left decrements.
  - The write that takes post_left to 0 sets state=DONE.
  - The pc comparison is not re-evaluated in POST.
- Drain, DONE only:
  - rd_valid = (count != 0); rd_data = entry at rd_ptr (combinational read of the register array).
  - On rd_valid && rd_ready: rd_ptr advances (wrapping) and count decrements.
  - rd_data must be held stable while rd_valid && !rd_ready.
  - rd_valid=0 in every state other than DONE, and rd_ready is ignored there.
  - commit_valid is ignored in IDLE and DONE, and dropped does not count it.
- dropped saturates at 16'hFFFF and never wraps.
- count never exceeds DEPTH.

Test Plan:
- Fill-stop (DEPTH=8, mode 0): arm, then 10 back-to-back commits with pc=0x100+4i. Required: state=DONE after the 8th; count=8; dropped=0; drain returns pc 0x100..0x11C in order, then rd_valid=0.
- Trigger with overwrite (mode 1, trig_pc=0x200, post=3): 20 commits pc=0x1C0+4i, trigger at i=16. Required: state=DONE after i=19; triggered=1; count=8; dropped=12; drain order pc 0x1F0..0x20C.
- Post=0 with an immediate stop: trig_pc=0x40 on the first commit. Required: count=1 and state=DONE in the same clock as the write. A later stop is ignored.
- Backpressure: rd_ready toggled 1,0,0,1 during the drain. Required: rd_data unchanged through the stall; no duplicate or skipped records.
- Coincident events: arm with commit_valid → count=0. stop with commit_valid in CAPTURE → the entry is not recorded. Reset asserted with 4 entries half-drained → every output at its reset value next cycle.
- Saturation: mode 1, no trigger, 65600 commits, then stop. Required: dropped=16'hFFFF, count=8.
